// File: rtl/sigmoid_req_scheduler_if.sv
// Bundle of request, sigmoid-unit and response signals around the shared sigmoid scheduler.
// slave is the scheduler's view; master is the surrounding requesters/datapath/consumer.
interface sigmoid_req_scheduler_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
);
  logic [N_REQ-1:0]    req_valid;
  logic [16*N_REQ-1:0] req_x;
  logic [N_REQ-1:0]    req_ready;
  logic [15:0]         sig_x;
  logic                sig_valid;
  logic [15:0]         sig_f_x;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [15:0]         rsp_data;
  logic [ID_W-1:0]     rsp_id;
  logic                busy;

  modport slave (
    input  req_valid, req_x, sig_f_x, rsp_ready,
    output req_ready, sig_x, sig_valid, rsp_valid, rsp_data, rsp_id, busy
  );

  modport master (
    output req_valid, req_x, sig_f_x, rsp_ready,
    input  req_ready, sig_x, sig_valid, rsp_valid, rsp_data, rsp_id, busy
  );
endinterface

// File: rtl/sigmoid_req_scheduler.sv
// Round-robin sharing of one fixed-latency sigmoid unit among N_REQ requesters, with
// ID tracking of in-flight operands and a credit-protected FWFT response FIFO.
module sigmoid_req_scheduler #(
  parameter int N_REQ      = 4,
  parameter int SIG_LAT    = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int ID_W       = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  sigmoid_req_scheduler_if.slave    bus
);
  localparam int DATA_W = 16;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int CW     = AW + 1;
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);

  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   cand;
  logic [ID_W-1:0]   grant_id;
  logic              grant_any;
  logic              credit_ok;
  logic              hs;
  logic [N_REQ-1:0]  grant;
  logic [DATA_W-1:0] x_arr [N_REQ];

  logic [CW-1:0]     inflight_cnt;
  logic [CW-1:0]     fifo_cnt;
  logic [CW:0]       outstanding;
  logic              push;
  logic              pop;
  logic              rsp_vld;

  logic              vld_p0;
  logic [DATA_W-1:0] x_p0;
  logic [ID_W-1:0]   id_p0;
  logic [SIG_LAT-1:0] vld_pipe;
  logic [ID_W-1:0]   id_pipe [SIG_LAT];

  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [ID_W-1:0]   fifo_id   [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign x_arr[g] = bus.req_x[DATA_W*g +: DATA_W];
  end

  // Every issued op holds a credit until the cycle after its result leaves the FIFO,
  // so a stalled consumer can never see more results than the FIFO can hold.
  assign outstanding = {1'b0, inflight_cnt} + {1'b0, fifo_cnt};
  assign credit_ok   = outstanding < (CW+1)'(FIFO_DEPTH);

  always_comb begin
    cand      = ptr;
    grant_id  = ptr;
    grant_any = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!grant_any && bus.req_valid[cand]) begin
        grant_any = 1'b1;
        grant_id  = cand;
      end
      cand = (cand == LAST_ID) ? '0 : cand + 1'b1;
    end
  end

  assign hs = grant_any && credit_ok && !reset;

  always_comb begin
    grant = '0;
    if (hs) grant[grant_id] = 1'b1;
  end

  assign bus.req_ready = grant;

  // ---- stage p0: operand register towards the sigmoid unit ----
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr    <= '0;
      vld_p0 <= 1'b0;
      x_p0   <= '0;
      id_p0  <= '0;
    end else begin
      vld_p0 <= hs;
      if (hs) begin
        x_p0  <= x_arr[grant_id];
        id_p0 <= grant_id;
        ptr   <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
      end
    end
  end

  assign bus.sig_valid = vld_p0;
  assign bus.sig_x     = x_p0;

  // ---- stages p1..pSIG_LAT: valid/ID chain aligned with the sigmoid latency ----
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
      for (int i = 0; i < SIG_LAT; i++) id_pipe[i] <= '0;
    end else begin
      vld_pipe[0] <= vld_p0;
      id_pipe[0]  <= id_p0;
      for (int i = 1; i < SIG_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        id_pipe[i]  <= id_pipe[i-1];
      end
    end
  end

  assign push = vld_pipe[SIG_LAT-1];
  assign pop  = rsp_vld && bus.rsp_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      inflight_cnt <= '0;
    end else begin
      case ({hs, push})
        2'b10:   inflight_cnt <= inflight_cnt + 1'b1;
        2'b01:   inflight_cnt <= inflight_cnt - 1'b1;
        default: inflight_cnt <= inflight_cnt;
      endcase
    end
  end

  // ---- response FIFO, first-word-fall-through ----
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) begin
      fifo_data[wr_ptr] <= bus.sig_f_x;
      fifo_id[wr_ptr]   <= id_pipe[SIG_LAT-1];
    end
  end

  assign rsp_vld      = (fifo_cnt != '0);
  assign bus.rsp_valid = rsp_vld;
  assign bus.rsp_data  = rsp_vld ? fifo_data[rd_ptr] : '0;
  assign bus.rsp_id    = rsp_vld ? fifo_id[rd_ptr]   : '0;
  assign bus.busy      = (inflight_cnt != '0) || rsp_vld;

endmodule

// File: tb/tb_sigmoid_req_scheduler.sv
// Directed bench for sigmoid_req_scheduler; the sigmoid unit is modelled as a
// SIG_LAT-deep pipeline returning x+1.
module tb_sigmoid_req_scheduler;
  localparam int N_REQ      = 4;
  localparam int SIG_LAT    = 3;
  localparam int FIFO_DEPTH = 4;
  localparam int ID_W       = 2;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  logic [15:0] xs [N_REQ];
  logic [15:0] m  [SIG_LAT];

  sigmoid_req_scheduler_if #(.N_REQ(N_REQ), .ID_W(ID_W)) bus ();

  sigmoid_req_scheduler #(
    .N_REQ(N_REQ), .SIG_LAT(SIG_LAT), .FIFO_DEPTH(FIFO_DEPTH), .ID_W(ID_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    m[0] <= bus.sig_x + 16'd1;
    for (int i = 1; i < SIG_LAT; i++) m[i] <= m[i-1];
  end
  assign bus.sig_f_x = m[SIG_LAT-1];

  always @(posedge clk) begin
    if (!reset)
      assert (!(dut.push && int'(dut.fifo_cnt) >= FIFO_DEPTH))
        else $error("FAIL push_when_full: fifo_cnt %0d", dut.fifo_cnt);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_x();
    bus.req_x = {xs[3], xs[2], xs[1], xs[0]};
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  function automatic int grant_idx(input logic [N_REQ-1:0] g);
    int r;
    r = -1;
    for (int i = 0; i < N_REQ; i++) if (g[i]) r = i;
    return r;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int hs_cnt;
    int stale;
    int gid;
    int issued;
    int got;
    int maxcnt;
    int exp_seq [6];
    int grants [$];
    int gcyc [$];
    int rsps [$];
    logic [17:0] expq [$];
    logic [17:0] e;

    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < N_REQ; i++) xs[i] = 16'h0;
    drive_x();

    // Reset state, with requests pending while reset is high
    bus.req_valid = 4'b1111;
    tick();
    tick();
    @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
    chk("rst_sig_valid", 32'(bus.sig_valid), 32'h0);
    chk("rst_sig_x",     32'(bus.sig_x),     32'h0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst_rsp_data",  32'(bus.rsp_data),  32'h0);
    chk("rst_rsp_id",    32'(bus.rsp_id),    32'h0);
    chk("rst_busy",      32'(bus.busy),      32'h0);

    // Single op
    do_reset();
    bus.rsp_ready = 1'b1;
    xs[0] = 16'h0400;
    drive_x();
    bus.req_valid = 4'b0001;
    @(negedge clk);
    chk("t1_ready", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = '0;
    @(negedge clk);
    chk("t1_sig_valid", 32'(bus.sig_valid), 32'h1);
    chk("t1_sig_x",     32'(bus.sig_x),     32'h0400);
    repeat (3) tick();
    @(negedge clk);
    chk("t1_rsp_early", 32'(bus.rsp_valid), 32'h0);
    tick();
    @(negedge clk);
    chk("t1_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    chk("t1_rsp_data",  32'(bus.rsp_data),  32'h0401);
    chk("t1_rsp_id",    32'(bus.rsp_id),    32'h0);
    chk("t1_busy",      32'(bus.busy),      32'h1);
    tick();
    @(negedge clk);
    chk("t1_drained",   32'(bus.rsp_valid), 32'h0);
    chk("t1_idle",      32'(bus.busy),      32'h0);
    chk("t1_sig_hold",  32'(bus.sig_x),     32'h0400);

    // Partial contention from ptr=0
    do_reset();
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b1010;
    @(negedge clk);
    chk("t4_g0", 32'(bus.req_ready), 32'b0010);
    tick();
    @(negedge clk);
    chk("t4_g1", 32'(bus.req_ready), 32'b1000);
    tick();
    @(negedge clk);
    chk("t4_g2", 32'(bus.req_ready), 32'b0010);
    tick();
    @(negedge clk);
    chk("t4_g3", 32'(bus.req_ready), 32'b1000);
    tick();
    bus.req_valid = '0;

    // Round robin with all requesters active
    do_reset();
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < N_REQ; i++) xs[i] = 16'(16'h0100 * (i + 1));
    drive_x();
    bus.req_valid = 4'b1111;
    exp_seq = '{0, 1, 2, 3, 0, 1};
    for (int c = 0; c < 60 && rsps.size() < 6; c++) begin
      @(negedge clk);
      if (bus.rsp_valid && bus.rsp_ready) rsps.push_back(int'(bus.rsp_id));
      gid = grant_idx(bus.req_ready & bus.req_valid);
      if (gid >= 0) begin
        grants.push_back(gid);
        gcyc.push_back(c);
      end
      tick();
      if (grants.size() >= 6) bus.req_valid = '0;
    end
    chk("t2_ngrant", 32'(grants.size()), 32'd6);
    chk("t2_nrsp",   32'(rsps.size()),   32'd6);
    for (int k = 0; k < grants.size() && k < 6; k++)
      chk($sformatf("t2_grant%0d", k), 32'(grants[k]), 32'(exp_seq[k]));
    for (int k = 0; k < rsps.size() && k < 6; k++)
      chk($sformatf("t2_rspid%0d", k), 32'(rsps[k]), 32'(exp_seq[k]));
    if (gcyc.size() >= 4) chk("t2_back2back", 32'(gcyc[3] - gcyc[0]), 32'd3);

    // Backpressure exhausts credits
    do_reset();
    xs[2] = 16'h2000;
    drive_x();
    bus.req_valid = 4'b0100;
    hs_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      gid = grant_idx(bus.req_ready & bus.req_valid);
      tick();
      if (gid >= 0) begin
        hs_cnt++;
        xs[2] = xs[2] + 16'd1;
        drive_x();
      end
    end
    chk("t3_hs", 32'(hs_cnt), 32'd4);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("t3_no_credit",  32'(bus.req_ready), 32'h0);
    chk("t3_head_valid", 32'(bus.rsp_valid), 32'h1);
    chk("t3_head0",      32'(bus.rsp_data),  32'h2001);
    tick();
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    chk("t3_regrant", 32'(bus.req_ready), 32'b0100);
    chk("t3_head1",   32'(bus.rsp_data),  32'h2002);
    tick();
    @(negedge clk);
    chk("t3_full_again", 32'(bus.req_ready), 32'h0);
    chk("t3_head_hold",  32'(bus.rsp_data),  32'h2002);

    // Reset with two ops in flight and one queued
    do_reset();
    xs[0] = 16'h1111; xs[1] = 16'h2222; xs[2] = 16'h3333;
    drive_x();
    bus.req_valid = 4'b0001;
    tick();
    bus.req_valid = '0;
    tick();
    tick();
    bus.req_valid = 4'b0010;
    tick();
    bus.req_valid = 4'b0100;
    tick();
    bus.req_valid = '0;
    reset = 1'b1;
    @(negedge clk);
    chk("t5_pre_queued", 32'(bus.rsp_valid), 32'h1);
    chk("t5_pre_busy",   32'(bus.busy),      32'h1);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("t5_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("t5_busy",      32'(bus.busy),      32'h0);
    chk("t5_sig_valid", 32'(bus.sig_valid), 32'h0);
    stale = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      @(negedge clk);
      if (bus.rsp_valid || bus.busy) stale++;
    end
    chk("t5_stale", 32'(stale), 32'd0);

    // Continuous issue with concurrent push/pop
    do_reset();
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < N_REQ; i++) xs[i] = 16'($urandom);
    drive_x();
    bus.req_valid = 4'b1111;
    issued = 0;
    got    = 0;
    maxcnt = 0;
    for (int c = 0; c < 2000 && got < 100; c++) begin
      @(negedge clk);
      if (int'(dut.fifo_cnt) > maxcnt) maxcnt = int'(dut.fifo_cnt);
      if (bus.rsp_valid) begin
        if (expq.size() == 0) begin
          chk("t6_unexpected", 32'(bus.rsp_data), 32'hFFFF_FFFF);
        end else begin
          e = expq.pop_front();
          chk("t6_data", 32'(bus.rsp_data), 32'(e[15:0]));
          chk("t6_id",   32'(bus.rsp_id),   32'(e[17:16]));
        end
        got++;
      end
      gid = grant_idx(bus.req_ready & bus.req_valid);
      if (gid >= 0) begin
        expq.push_back({2'(gid), xs[gid] + 16'd1});
        issued++;
      end
      tick();
      if (gid >= 0) begin
        xs[gid] = 16'($urandom);
        drive_x();
        if (issued >= 100) bus.req_valid = '0;
      end
    end
    chk("t6_count",    32'(got),         32'd100);
    chk("t6_leftover", 32'(expq.size()), 32'd0);
    chk("t6_fifo_max", 32'(maxcnt),      32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
